// File: rtl/apb_master_bridge_p.sv
// APB3/APB4 manager for the NI: pops one request, runs one APB transfer with
// slave decode and ready-timeout, then pushes a tagged response.
module apb_master_bridge_p #(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 32,
  parameter int NUM_SLAVES     = 4,
  parameter int ID_W           = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_fifo_empty,
  output logic                  req_fifo_rreq,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_strb,
  input  logic [ID_W-1:0]       req_id,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  input  logic                  resp_fifo_full,
  output logic                  resp_fifo_wreq,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  resp_timeout,
  output logic [ID_W-1:0]       resp_id,
  output logic                  busy
);
  localparam int SEL_W    = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int STRB_W   = DATA_W / 8;
  localparam int CNT_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int CNT_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, SETUP, ACCESS, RESP} state_t;

  state_t state, state_nxt;
  logic [CNT_W-1:0]      to_cnt;
  logic [SEL_W-1:0]      sel_idx;
  logic                  sel_ok;
  logic                  to_expired;

  logic                  rreq_d, wreq_d, penable_d, pwrite_d, err_d, tmo_d, busy_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic [ADDR_W-1:0]     paddr_d;
  logic [DATA_W-1:0]     pwdata_d, rdata_d;
  logic [STRB_W-1:0]     pstrb_d;
  logic [ID_W-1:0]       id_d;

  assign sel_idx    = req_addr[ADDR_W-1 -: SEL_W];
  assign sel_ok     = int'(sel_idx) < NUM_SLAVES;
  assign to_expired = (TIMEOUT_CYCLES != 0) && (to_cnt == CNT_W'(CNT_LAST));

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!req_fifo_empty) state_nxt = FETCH;
      FETCH:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = sel_ok ? SETUP : RESP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (PREADY || to_expired) state_nxt = RESP;
      RESP:    if (resp_fifo_wreq) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a register; this block computes its value for the next cycle.
  always_comb begin
    rreq_d    = 1'b0;
    wreq_d    = 1'b0;
    psel_d    = '0;
    penable_d = 1'b0;
    paddr_d   = PADDR;
    pwrite_d  = PWRITE;
    pwdata_d  = PWDATA;
    pstrb_d   = PSTRB;
    rdata_d   = resp_rdata;
    err_d     = resp_err;
    tmo_d     = resp_timeout;
    id_d      = resp_id;
    busy_d    = (state_nxt != IDLE);
    unique case (state)
      IDLE:    rreq_d = (state_nxt == FETCH);
      CAPTURE: begin
        id_d = req_id;
        if (sel_ok) begin
          psel_d   = NUM_SLAVES'(1) << sel_idx;
          paddr_d  = req_addr;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b0;
          wreq_d  = !resp_fifo_full;
        end
      end
      SETUP: begin
        psel_d    = PSEL;
        penable_d = 1'b1;
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_d = (!PWRITE && !PSLVERR) ? PRDATA : '0;
          err_d   = PSLVERR;
          tmo_d   = 1'b0;
          wreq_d  = !resp_fifo_full;
        end else if (to_expired) begin
          rdata_d = '0;
          err_d   = 1'b1;
          tmo_d   = 1'b1;
          wreq_d  = !resp_fifo_full;
        end else begin
          psel_d    = PSEL;
          penable_d = 1'b1;
        end
      end
      // Push only once; a push already issued this cycle ends the RESP stay.
      RESP:    wreq_d = !resp_fifo_wreq && !resp_fifo_full;
      default: ;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      req_fifo_rreq  <= 1'b0;
      resp_fifo_wreq <= 1'b0;
      PSEL           <= '0;
      PENABLE        <= 1'b0;
      PADDR          <= '0;
      PWRITE         <= 1'b0;
      PWDATA         <= '0;
      PSTRB          <= '0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      resp_timeout   <= 1'b0;
      resp_id        <= '0;
      busy           <= 1'b0;
    end else begin
      req_fifo_rreq  <= rreq_d;
      resp_fifo_wreq <= wreq_d;
      PSEL           <= psel_d;
      PENABLE        <= penable_d;
      PADDR          <= paddr_d;
      PWRITE         <= pwrite_d;
      PWDATA         <= pwdata_d;
      PSTRB          <= pstrb_d;
      resp_rdata     <= rdata_d;
      resp_err       <= err_d;
      resp_timeout   <= tmo_d;
      resp_id        <= id_d;
      busy           <= busy_d;
    end
  end

  // Counts ACCESS cycles of the current transfer; saturates instead of wrapping.
  always_ff @(posedge PCLK) begin
    if (PRESET || state_nxt == SETUP)        to_cnt <= '0;
    else if (state == ACCESS && to_cnt != '1) to_cnt <= to_cnt + 1'b1;
  end
endmodule

// File: tb/tb_apb_master_bridge_p.sv
// Bench for apb_master_bridge_p: request FIFO and APB slave models, response scoreboard.
`timescale 1ns/1ps
module tb_apb_master_bridge_p;
  localparam int ADDR_W = 14, DATA_W = 32, NUM_SLAVES = 3, ID_W = 4, TO = 8;

  logic PCLK = 1'b0;
  logic PRESET;
  logic req_fifo_empty, req_fifo_rreq, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0] req_strb;
  logic [ID_W-1:0] req_id;
  logic [ADDR_W-1:0] PADDR;
  logic [NUM_SLAVES-1:0] PSEL;
  logic PENABLE, PWRITE, PREADY, PSLVERR;
  logic [DATA_W-1:0] PWDATA, PRDATA;
  logic [3:0] PSTRB;
  logic resp_fifo_full, resp_fifo_wreq, resp_err, resp_timeout, busy;
  logic [DATA_W-1:0] resp_rdata;
  logic [ID_W-1:0] resp_id;

  apb_master_bridge_p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLAVES(NUM_SLAVES),
                        .ID_W(ID_W), .TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_fifo_empty(req_fifo_empty), .req_fifo_rreq(req_fifo_rreq),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .req_id(req_id), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .resp_fifo_full(resp_fifo_full), .resp_fifo_wreq(resp_fifo_wreq), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_timeout(resp_timeout), .resp_id(resp_id), .busy(busy));

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  id;
    int          w;       // wait states before PREADY
    logic [31:0] prdata;
    logic        slverr;
  } req_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
    logic [3:0]  id;
    int          lat;     // cycles from the pop to the push
  } rsp_t;

  req_t req_q[$];
  req_t slv_q[$];
  rsp_t exp_q[$];
  int   rreq_log[$];
  int   n_chk = 0, n_pass = 0, cyc = 0, n_push = 0, n_rreq = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic req_t mk(logic wr, logic [13:0] addr, logic [31:0] wd, logic [3:0] st,
                              logic [3:0] id, int w, logic [31:0] prd, logic se);
    req_t r;
    r.wr = wr; r.addr = addr; r.wdata = wd; r.strb = st; r.id = id;
    r.w = w; r.prdata = prd; r.slverr = se;
    return r;
  endfunction

  // Expected response from the transfer rules: decode error, timeout after TO
  // ACCESS cycles, otherwise the slave's answer.
  function automatic rsp_t model(req_t r);
    rsp_t e;
    e.id = r.id;
    if (int'(r.addr[13:12]) >= NUM_SLAVES) begin
      e.rdata = 0; e.err = 1; e.tmo = 0; e.lat = 2;
    end else if (r.w + 1 > TO) begin
      e.rdata = 0; e.err = 1; e.tmo = 1; e.lat = 3 + TO;
    end else begin
      e.rdata = (!r.wr && !r.slverr) ? r.prdata : 32'h0;
      e.err = r.slverr; e.tmo = 0; e.lat = 3 + r.w + 1;
    end
    return e;
  endfunction

  task automatic issue(req_t r);
    exp_q.push_back(model(r));
    if (int'(r.addr[13:12]) < NUM_SLAVES) slv_q.push_back(r);
    req_q.push_back(r);
  endtask

  initial forever begin
    @(posedge PCLK);
    cyc++;
  end

  // Request FIFO: data appears the cycle after a pop, then turns to garbage.
  initial begin
    req_t r;
    bit hold;
    hold = 0;
    req_fifo_empty = 1; req_write = 0; req_addr = 0; req_wdata = 0; req_strb = 0; req_id = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) hold = 0;
      else if (req_fifo_rreq) begin
        check("rreq_with_data", req_q.size() != 0, 1);
        if (req_q.size() != 0) begin
          r = req_q.pop_front();
          req_write = r.wr; req_addr = r.addr; req_wdata = r.wdata; req_strb = r.strb; req_id = r.id;
        end
        hold = 1;
      end else if (hold) hold = 0;
      else begin
        req_write = 1'($urandom); req_addr = 14'($urandom); req_wdata = $urandom;
        req_strb = 4'($urandom); req_id = 4'($urandom);
      end
      req_fifo_empty = (req_q.size() == 0);
    end
  end

  // APB slave: checks SETUP contents and ACCESS stability, answers after w wait states.
  initial begin
    req_t cur;
    int acc, exp_acc;
    bit in_x;
    logic [NUM_SLAVES-1:0] exp_sel;
    in_x = 0; acc = 0; exp_sel = '0;
    PREADY = 0; PRDATA = 0; PSLVERR = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        in_x = 0; acc = 0; PREADY = 0;
      end else if (PSEL != 0 && !PENABLE) begin
        check("setup_expected", slv_q.size() != 0, 1);
        if (slv_q.size() != 0) begin
          cur = slv_q.pop_front();
          in_x = 1; acc = 0;
          exp_sel = NUM_SLAVES'(1) << cur.addr[13:12];
          check("setup_psel", PSEL, exp_sel);
          check("setup_paddr", PADDR, cur.addr);
          check("setup_pwrite", PWRITE, cur.wr);
          check("setup_pwdata", PWDATA, cur.wdata);
          check("setup_pstrb", PSTRB, cur.wr ? cur.strb : 4'h0);
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end else if (PENABLE) begin
        check("access_in_transfer", {in_x, PSEL != 0}, 2'b11);
        check("access_stable", {PSEL, PADDR, PWRITE, PWDATA, PSTRB},
              {exp_sel, cur.addr, cur.wr, cur.wdata, cur.wr ? cur.strb : 4'h0});
        acc++;
        if (acc == cur.w + 1) begin
          PREADY = 1; PRDATA = cur.prdata; PSLVERR = cur.slverr;
        end else begin
          PREADY = 0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        end
      end else begin
        if (in_x) begin
          exp_acc = (cur.w + 1 < TO) ? cur.w + 1 : TO;
          check("access_cycles", acc, exp_acc);
          in_x = 0;
        end
        PREADY = 1'($urandom); PRDATA = $urandom; PSLVERR = 1'($urandom);
      end
    end
  end

  // Response monitor: pops the scoreboard on every push.
  initial begin
    rsp_t e;
    bit outst, full_seen;
    int last_rreq;
    outst = 0; full_seen = 0; last_rreq = 0;
    forever begin
      @(negedge PCLK);
      if (PRESET) begin
        outst = 0; full_seen = 0;
      end else begin
        if (resp_fifo_full) full_seen = 1;
        if (resp_fifo_wreq) begin
          n_push++;
          check("push_while_full", resp_fifo_full, 0);
          check("push_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", resp_err, e.err);
            check("resp_timeout", resp_timeout, e.tmo);
            check("resp_id", resp_id, e.id);
            if (!full_seen) check("push_latency", cyc - last_rreq, e.lat);
          end
          outst = 0;
        end
        if (req_fifo_rreq) begin
          n_rreq++;
          check("single_outstanding", outst, 0);
          outst = 1;
          full_seen = resp_fifo_full;
          last_rreq = cyc;
          rreq_log.push_back(cyc);
        end
      end
    end
  end

  task automatic check_reset_outputs(string tag);
    check({tag, "_apb_zero"}, {PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB}, 64'h0);
    check({tag, "_ni_zero"}, {req_fifo_rreq, resp_fifo_wreq, resp_rdata, resp_err,
                             resp_timeout, resp_id, busy}, 64'h0);
  endtask

  task automatic wait_drain(int budget);
    int k;
    k = 0;
    do begin
      @(negedge PCLK);
      k++;
    end while ((exp_q.size() != 0 || req_q.size() != 0 || busy) && k < budget);
    check("drain_pending", exp_q.size() + req_q.size() + int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int push0, rreq0, k;
    req_t r;
    PRESET = 1; resp_fifo_full = 0;
    repeat (3) @(negedge PCLK);
    check_reset_outputs("por");
    PRESET = 0;

    issue(mk(0, 14'h0010, 32'h0, 4'hF, 4'h5, 0, 32'hDEADBEEF, 0));
    wait_drain(60);
    issue(mk(1, 14'h2004, 32'h12345678, 4'b0011, 4'h6, 3, 32'hCAFEF00D, 0));
    issue(mk(0, 14'h3004, 32'h0, 4'hF, 4'h7, 0, 32'h55555555, 0));
    issue(mk(0, 14'h1008, 32'h0, 4'hF, 4'h8, 1, 32'h11112222, 1));
    issue(mk(0, 14'h0100, 32'h0, 4'hF, 4'h9, 20, 32'h33334444, 0));
    issue(mk(0, 14'h1100, 32'h0, 4'hF, 4'hA, 7, 32'hA5A5A5A5, 0));
    issue(mk(1, 14'h2200, 32'h9ABCDEF0, 4'b1100, 4'hB, 8, 32'h0, 0));
    wait_drain(200);

    // Response FIFO full across completion.
    @(negedge PCLK);
    resp_fifo_full = 1;
    push0 = n_push; rreq0 = n_rreq;
    issue(mk(0, 14'h1040, 32'h0, 4'hF, 4'hC, 0, 32'h0BADF00D, 0));
    issue(mk(1, 14'h0044, 32'h77778888, 4'hF, 4'hD, 0, 32'h0, 0));
    repeat (16) @(negedge PCLK);
    check("full_no_push", n_push, push0);
    check("full_busy", busy, 1);
    check("full_no_new_rreq", n_rreq, rreq0 + 1);
    resp_fifo_full = 0;
    repeat (3) @(negedge PCLK);
    check("full_single_push", n_push, push0 + 1);
    wait_drain(60);

    for (int i = 0; i < 40; i++) begin
      r.wr = 1'($urandom); r.addr = 14'($urandom); r.wdata = $urandom; r.strb = 4'($urandom);
      r.id = 4'($urandom); r.prdata = $urandom; r.slverr = ($urandom_range(0, 7) == 0);
      r.w = ($urandom_range(0, 9) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 4));
      issue(r);
      repeat ($urandom_range(0, 8)) @(negedge PCLK);
    end
    wait_drain(2000);

    // Reset in the middle of ACCESS drops the transfer; queued requests then run in order.
    issue(mk(0, 14'h1200, 32'h0, 4'hF, 4'hE, 30, 32'h0, 0));
    k = 0;
    while (!PENABLE && k < 30) begin
      @(negedge PCLK);
      k++;
    end
    check("reach_access", PENABLE, 1);
    PRESET = 1;
    exp_q.delete(); slv_q.delete(); rreq_log.delete();
    issue(mk(0, 14'h0020, 32'h0, 4'hF, 4'h1, 0, 32'h10101010, 0));
    issue(mk(1, 14'h1024, 32'h20202020, 4'b0101, 4'h2, 0, 32'h0, 0));
    issue(mk(0, 14'h2028, 32'h0, 4'hF, 4'h3, 0, 32'h30303030, 0));
    @(negedge PCLK);
    check_reset_outputs("mid");
    repeat (3) @(negedge PCLK);
    check("no_rreq_in_reset", rreq_log.size(), 0);
    PRESET = 0;
    wait_drain(100);
    check("post_reset_pops", rreq_log.size(), 3);
    if (rreq_log.size() == 3) begin
      check("issue_spacing_1", rreq_log[1] - rreq_log[0], 6);
      check("issue_spacing_2", rreq_log[2] - rreq_log[1], 6);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/apb_master_bridge_p.md
Name: apb_master_bridge_p

Overview:
- Parametrised successor of the NI's APB manager. Pops one request from the NI request FIFO and runs one APB3/APB4 transfer (with PSTRB).
- Decodes the slave select from the upper address bits into a one-hot PSEL vector.
- Aborts transfers on a ready-timeout.
- Pushes a tagged response (read data, error, timeout flag, ID) into the NI response FIFO.
- Sits between the NI depacketiser FIFOs and the APB slave fabric.

Parameters:
- ADDR_W, 14, PADDR width; the top SEL_W bits select the slave.
- DATA_W, 32, PWDATA/PRDATA width; multiple of 8.
- NUM_SLAVES, 4, PSEL vector width, >=1; SEL_W = max(1, clog2(NUM_SLAVES)).
- ID_W, 4, transaction tag width, echoed to the response.
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles without PREADY; 0 disables the timeout.

Ports:
- PCLK  in  1  clock
- PRESET  in  1  reset; one clock; reset is synchronous and active-high
- req_fifo_empty  in  1  request FIFO empty
- req_fifo_rreq  out  1  request FIFO pop; data valid the following cycle
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- req_strb  in  DATA_W/8  write byte strobes
- req_id  in  ID_W  transaction tag
- PADDR  out  ADDR_W  APB address
- PSEL  out  NUM_SLAVES  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PSTRB  out  DATA_W/8  APB strobes; forced 0 on reads
- PRDATA  in  DATA_W  slave read data, already muxed
- PREADY  in  1  slave ready, already muxed
- PSLVERR  in  1  slave error, already muxed
- resp_fifo_full  in  1  response FIFO full
- resp_fifo_wreq  out  1  response FIFO push
- resp_rdata  out  DATA_W  read data; 0 for writes and errors
- resp_err  out  1  PSLVERR, decode error or timeout
- resp_timeout  out  1  error caused by timeout
- resp_id  out  ID_W  echoed req_id
- busy  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. On reset every output is 0, the FSM goes to IDLE and the timeout counter clears. PRESET has priority in any state; any in-flight APB transfer and any pending response are dropped.
- FSM states: IDLE, FETCH, CAPTURE, SETUP, ACCESS, RESP.
  - IDLE: when !req_fifo_empty, go to FETCH.
  - FETCH: req_fifo_rreq=1 for exactly one cycle, then go to CAPTURE.
  - CAPTURE: latch write, addr, wdata, strb and id into internal registers. Index = addr[ADDR_W-1 -: SEL_W].
    - If index >= NUM_SLAVES: go to RESP with err=1, timeout=0, rdata=0. No APB activity occurs.
    - Otherwise go to SETUP.
  - SETUP: PSEL[index]=1, PENABLE=0. PADDR, PWRITE, PWDATA and PSTRB are driven from the latched copies. Go to ACCESS.
  - ACCESS: PENABLE=1; address, control and data are held stable.
    - When PREADY: capture PRDATA (reads only) and PSLVERR into the response registers, go to RESP.
    - When the counter reaches TIMEOUT_CYCLES-1 without PREADY: set err=1, timeout=1, rdata=0, go to RESP.
    - PREADY in the same cycle as expiry counts as a normal completion.
  - RESP: PSEL=0 and PENABLE=0. PADDR, PWRITE, PWDATA and PSTRB hold their last values. resp_fifo_wreq=1 for exactly one cycle in the first RESP cycle with !resp_fifo_full, with resp_* valid that cycle. Then go to IDLE. Stay in RESP while the FIFO is full.
- Timeout counter: clears on SETUP entry and increments each ACCESS cycle. Width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Latency: with zero wait states and a non-full response FIFO, push happens 5 cycles after the IDLE→FETCH decision. The minimum issue interval is 6 cycles per request.
- Strict order: one outstanding transfer, and the next FETCH never starts before the response push.
- req_fifo_rreq is never asserted while req_fifo_empty=1 is sampled in IDLE.
- Request fields are sampled only in CAPTURE; changes on them at any other time are ignored.

Test Plan:
- Read, slave 0, addr 0x0010, PREADY=1 immediately, PRDATA=0xDEADBEEF → PSEL=0001 for one SETUP and one ACCESS cycle; push resp_rdata=0xDEADBEEF, err=0, id echoed; push 5 cycles after the pop decision.
- Write to addr 0x3004 (slave 3), wdata 0x12345678, strb 0b0011, PREADY after 3 wait states → PSEL=1000; PENABLE high for 4 cycles; PWDATA/PSTRB stable throughout; response rdata=0, err=0.
- NUM_SLAVES=3, request to index 3 → no PSEL/PENABLE activity; response err=1, timeout=0.
- TIMEOUT_CYCLES=8, PREADY held 0 → PENABLE drops after 8 ACCESS cycles; response err=1, timeout=1. Repeat with PREADY arriving exactly on cycle 8 → normal completion, err=0.
- resp_fifo_full=1 for 10 cycles at completion → remains in RESP, no wreq, no new rreq; single wreq in the cycle full deasserts.
- PRESET asserted mid-ACCESS, then 3 queued requests → all outputs 0 next cycle; after release the 3 requests complete in order with ids 1, 2, 3 and a 6-cycle spacing.
